avalon_mem_port: RTL and testbench
==================================

// Module: avalon_mem_port
// PURPOSE
//  Parametrised Avalon-MM master port for the multicycle MIPS core: the next generation of the core's memory path.
//  Takes one CPU load/store request at a time, drives the Avalon bus, and generates byte lanes for byte, half and word accesses.
//  Adds sign/zero extension, misalignment trapping, a configurable fixed read latency and a bus-hang timeout.
//  Sits between the core datapath/state machine and the external Avalon slave.
// PARAMETERS
//  ADDR_W        32  CPU and bus address width.
//  DATA_W        32  Bus data width. Legal values: 32 or 64. BYTES = DATA_W/8, OFS_W = log2(BYTES).
//  READ_LATENCY  0   Extra cycles after the read is accepted (read && !waitrequest) before readdata is valid. Range 0..7.
//  TIMEOUT       0   Max cycles a transfer may be held by waitrequest. 0 = no timeout.
// PORTS
//  clk           in   1       Clock.
//  reset         in   1       Asynchronous, active-high reset.
//  req           in   1       Request strobe. Sampled only in IDLE.
//  req_write     in   1       1 = store, 0 = load.
//  req_size      in   2       0 = byte, 1 = half, 2 = word, 3 = full bus width (BYTES bytes).
//  req_signed    in   1       Loads: 1 = sign-extend, 0 = zero-extend.
//  req_addr      in   ADDR_W  Byte address.
//  req_wdata     in   DATA_W  Store data, right-aligned.
//  busy          out  1       High in every state except IDLE.
//  resp_valid    out  1       One-cycle completion pulse, for loads and stores alike.
//  resp_rdata    out  DATA_W  Extended load data. Valid while resp_valid is high.
//  err_misalign  out  1       Pulses with resp_valid when the access was misaligned.
//  err_timeout   out  1       Pulses with resp_valid when the transfer timed out.
//  address       out  ADDR_W  Avalon address: req_addr with its OFS_W LSBs cleared.
//  read/write    out  1       Avalon strobes. Never both high.
//  waitrequest   in   1       Avalon stall.
//  writedata     out  DATA_W  Store data, lane-replicated.
//  byteenable    out  BYTES   Active byte lanes.
//  readdata      in   DATA_W  Avalon read data.
// BEHAVIOUR
//  Reset: every output goes to 0 immediately and the state goes to IDLE. A reset mid-transfer drops the transfer; no response.
//  All outputs are registered.
//  States:
//   IDLE -> REQ  on req with an aligned access.
//   IDLE -> RESP on req with a misaligned access; err_misalign is set and no bus cycle occurs.
//   REQ:  read/write, address, byteenable and writedata are asserted and held stable while waitrequest=1.
//         On !waitrequest the strobe drops the next cycle. Then a write goes to RESP.
//         A read goes to LAT if READ_LATENCY>0, else to RESP capturing readdata in that same accepting cycle.
//   LAT:  counts READ_LATENCY cycles and captures readdata on the last one, then goes to RESP.
//   RESP: resp_valid=1 for one cycle, then IDLE. A new req is accepted no earlier than the following cycle.
//  Alignment:
//   Half needs addr[0]=0. Word needs addr[1:0]=0. Size 3 needs addr[OFS_W-1:0]=0.
//   Size 3 with DATA_W=32 is treated as word.
//  byteenable: size-wide mask shifted left by addr[OFS_W-1:0].
//  writedata: the low 2^size bytes of req_wdata replicated across every lane.
//  Read data:
//   The selected lanes are shifted down by the offset and extended to DATA_W per req_signed.
//   Size 3 is passed through unchanged.
//  Timeout (TIMEOUT>0):
//   A counter increments each REQ cycle with waitrequest=1.
//   When it reaches TIMEOUT the strobe drops, err_timeout is set, the state goes to RESP and resp_rdata=0.
//  Latency (waitrequest low, READ_LATENCY=0): req at cycle N -> strobe at N+1 -> resp_valid at N+2.
//  req, or any change to the req_* inputs, while busy is ignored.
// TESTING
//  LB, addr 0x1003, req_signed=1, readdata 0x80FF1234 -> address 0x1000, byteenable 4'b1000, resp_rdata 0xFFFFFF80. Same access with LBU -> 0x00000080.
//  SH, addr 0x2002, wdata 0x0000BEEF -> write=1, writedata 0xBEEFBEEF, byteenable 4'b1100, resp_valid 2 cycles after req.
//  LW, addr 0x1001 -> read never asserted; resp_valid and err_misalign pulse on the next cycle.
//  waitrequest held high 3 cycles -> read, address and byteenable stable for 4 cycles; readdata 0xCAFEF00D returned.
//  TIMEOUT=8, waitrequest stuck high -> read high for exactly 8 cycles; err_timeout=1, resp_rdata=0.
//  Reset asserted in LAT (READ_LATENCY=3) -> all outputs 0 at once; no resp_valid; next req after reset completes normally.

Source files
------------

// File: rtl/avalon_mem_port_if.sv
// Bundle of the CPU request/response signals and the Avalon-MM master bus for avalon_mem_port.
// The master modport is the port's view, and the slave modport is the CPU/bus side.
interface avalon_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              err_misalign;
  logic              err_timeout;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [BYTES-1:0]  byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  req, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output busy, resp_valid, resp_rdata, err_misalign, err_timeout,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output req, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  busy, resp_valid, resp_rdata, err_misalign, err_timeout,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/avalon_mem_port.sv
// Avalon-MM master port for the multicycle MIPS core: one load/store at a time, with byte lanes,
// load extension, misalignment trap, fixed read latency and a waitrequest timeout.
module avalon_mem_port #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  avalon_mem_port_if.master  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam logic [31:0] LAT_LAST = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [31:0] TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LAT, S_RESP} state_t;

  state_t            r_state, w_state_next;
  logic [31:0]       r_cnt, w_cnt_next;
  logic              r_is_write, w_is_write_next;
  logic [1:0]        r_size, w_size_next;
  logic              r_signed, w_signed_next;
  logic [OFS_W-1:0]  r_ofs, w_ofs_next;
  logic              r_busy, w_busy_next;
  logic              r_resp_valid, w_resp_valid_next;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_next;
  logic              r_err_misalign, w_err_misalign_next;
  logic              r_err_timeout, w_err_timeout_next;
  logic [ADDR_W-1:0] r_address, w_address_next;
  logic              r_read, w_read_next;
  logic              r_write, w_write_next;
  logic [DATA_W-1:0] r_writedata, w_writedata_next;
  logic [BYTES-1:0]  r_byteenable, w_byteenable_next;

  logic [1:0]        w_size;
  logic [OFS_W-1:0]  w_ofs;
  logic [OFS_W-1:0]  w_ofs_mask;
  logic [BYTES-1:0]  w_lane_mask;
  logic              w_misalign;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_rd_shift;
  logic [DATA_W-1:0] w_rd_keep;
  logic              w_rd_msb;
  logic [DATA_W-1:0] w_rdata_ext;

  // A full-bus access on a 32-bit bus is just a word.
  assign w_size = (DATA_W == 32 && bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
  assign w_ofs  = bus.req_addr[OFS_W-1:0];

  always_comb begin
    w_lane_mask = '1;
    w_ofs_mask  = '1;
    case (w_size)
      2'd0:    begin w_lane_mask = BYTES'(1);  w_ofs_mask = '0;         end
      2'd1:    begin w_lane_mask = BYTES'(3);  w_ofs_mask = OFS_W'(1);  end
      2'd2:    begin w_lane_mask = BYTES'(15); w_ofs_mask = OFS_W'(3);  end
      default: begin w_lane_mask = '1;         w_ofs_mask = '1;         end
    endcase
  end

  assign w_misalign = |(w_ofs & w_ofs_mask);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_wdata_rep[gi*8 +: 8] =
        (w_size == 2'd0) ? bus.req_wdata[7:0] :
        (w_size == 2'd1) ? bus.req_wdata[(gi % 2)*8 +: 8] :
        (w_size == 2'd2) ? bus.req_wdata[(gi % 4)*8 +: 8] :
                           bus.req_wdata[gi*8 +: 8];
    end
  endgenerate

  // Load path: bring the addressed lanes down to bit 0, then fill the upper bits.
  always_comb begin
    w_rd_shift = bus.readdata >> {r_ofs, 3'b000};
    w_rd_keep  = '1;
    w_rd_msb   = 1'b0;
    case (r_size)
      2'd0:    begin w_rd_keep = DATA_W'(8'hFF);         w_rd_msb = w_rd_shift[7];  end
      2'd1:    begin w_rd_keep = DATA_W'(16'hFFFF);      w_rd_msb = w_rd_shift[15]; end
      2'd2:    begin w_rd_keep = DATA_W'(32'hFFFF_FFFF); w_rd_msb = w_rd_shift[31]; end
      default: begin w_rd_keep = '1;                     w_rd_msb = 1'b0;           end
    endcase
    w_rdata_ext = (w_rd_shift & w_rd_keep) | ((r_signed && w_rd_msb) ? ~w_rd_keep : '0);
  end

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_is_write_next     = r_is_write;
    w_size_next         = r_size;
    w_signed_next       = r_signed;
    w_ofs_next          = r_ofs;
    w_resp_valid_next   = 1'b0;
    w_resp_rdata_next   = r_resp_rdata;
    w_err_misalign_next = 1'b0;
    w_err_timeout_next  = 1'b0;
    w_address_next      = r_address;
    w_read_next         = r_read;
    w_write_next        = r_write;
    w_writedata_next    = r_writedata;
    w_byteenable_next   = r_byteenable;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_is_write_next   = bus.req_write;
          w_size_next       = w_size;
          w_signed_next     = bus.req_signed;
          w_ofs_next        = w_ofs;
          w_resp_rdata_next = '0;
          w_cnt_next        = '0;
          if (w_misalign) begin
            w_state_next        = S_RESP;
            w_resp_valid_next   = 1'b1;
            w_err_misalign_next = 1'b1;
          end else begin
            w_state_next      = S_REQ;
            w_read_next       = !bus.req_write;
            w_write_next      = bus.req_write;
            w_address_next    = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            w_byteenable_next = w_lane_mask << w_ofs;
            w_writedata_next  = w_wdata_rep;
          end
        end
      end
      S_REQ: begin
        if (!bus.waitrequest) begin
          w_read_next  = 1'b0;
          w_write_next = 1'b0;
          w_cnt_next   = '0;
          if (r_is_write) begin
            w_state_next      = S_RESP;
            w_resp_valid_next = 1'b1;
          end else if (READ_LATENCY == 0) begin
            w_state_next      = S_RESP;
            w_resp_valid_next = 1'b1;
            w_resp_rdata_next = w_rdata_ext;
          end else begin
            w_state_next = S_LAT;
          end
        end else if (TIMEOUT > 0 && r_cnt == TO_LAST) begin
          w_read_next        = 1'b0;
          w_write_next       = 1'b0;
          w_state_next       = S_RESP;
          w_resp_valid_next  = 1'b1;
          w_err_timeout_next = 1'b1;
          w_resp_rdata_next  = '0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_LAT: begin
        if (r_cnt == LAT_LAST) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = w_rdata_ext;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_next      = S_IDLE;
        w_resp_rdata_next = '0;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_is_write     <= 1'b0;
      r_size         <= '0;
      r_signed       <= 1'b0;
      r_ofs          <= '0;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_address      <= '0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_writedata    <= '0;
      r_byteenable   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_is_write     <= w_is_write_next;
      r_size         <= w_size_next;
      r_signed       <= w_signed_next;
      r_ofs          <= w_ofs_next;
      r_busy         <= w_busy_next;
      r_resp_valid   <= w_resp_valid_next;
      r_resp_rdata   <= w_resp_rdata_next;
      r_err_misalign <= w_err_misalign_next;
      r_err_timeout  <= w_err_timeout_next;
      r_address      <= w_address_next;
      r_read         <= w_read_next;
      r_write        <= w_write_next;
      r_writedata    <= w_writedata_next;
      r_byteenable   <= w_byteenable_next;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.err_misalign = r_err_misalign;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.address      = r_address;
  assign bus.read         = r_read;
  assign bus.write        = r_write;
  assign bus.writedata    = r_writedata;
  assign bus.byteenable   = r_byteenable;
endmodule

// File: tb/tb_avalon_mem_port.sv
// Directed bench for avalon_mem_port: port A has zero read latency and TIMEOUT=8, port B has READ_LATENCY=3.
module tb_avalon_mem_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avalon_mem_port_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  avalon_mem_port_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  avalon_mem_port #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa.master));
  avalon_mem_port #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .TIMEOUT(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb.master));

  bit          sel = 1'b0;
  logic        t_req = 1'b0, t_write = 1'b0, t_signed = 1'b0, t_wait = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;

  assign ifa.req = t_req & ~sel;  assign ifb.req = t_req & sel;
  assign ifa.req_write = t_write; assign ifb.req_write = t_write;
  assign ifa.req_size = t_size;   assign ifb.req_size = t_size;
  assign ifa.req_signed = t_signed; assign ifb.req_signed = t_signed;
  assign ifa.req_addr = t_addr;   assign ifb.req_addr = t_addr;
  assign ifa.req_wdata = t_wdata; assign ifb.req_wdata = t_wdata;
  assign ifa.waitrequest = t_wait; assign ifb.waitrequest = t_wait;
  assign ifa.readdata = t_rdata;  assign ifb.readdata = t_rdata;

  wire        o_busy  = sel ? ifb.busy : ifa.busy;
  wire        o_rv    = sel ? ifb.resp_valid : ifa.resp_valid;
  wire [31:0] o_rdata = sel ? ifb.resp_rdata : ifa.resp_rdata;
  wire        o_mis   = sel ? ifb.err_misalign : ifa.err_misalign;
  wire        o_tmo   = sel ? ifb.err_timeout : ifa.err_timeout;
  wire [31:0] o_addr  = sel ? ifb.address : ifa.address;
  wire        o_read  = sel ? ifb.read : ifa.read;
  wire        o_write = sel ? ifb.write : ifa.write;
  wire [31:0] o_wd    = sel ? ifb.writedata : ifa.writedata;
  wire [3:0]  o_be    = sel ? ifb.byteenable : ifa.byteenable;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it to its response; waitrequest is held for the first 'hold' strobe cycles.
  task automatic run_access(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] ad,
                            input logic [31:0] wd, input int hold,
                            output logic [31:0] rd, output int lat, output bit mis, output bit tmo,
                            output int scyc, output logic [31:0] a0, output logic [3:0] be0,
                            output logic [31:0] wd0, output bit wr0, output bit stable,
                            output bit ok, output bit rv_after);
    @(negedge clk);
    t_req = 1'b1; t_write = w; t_size = sz; t_signed = sg; t_addr = ad; t_wdata = wd; t_wait = 1'b0;
    rd = '0; lat = 0; mis = 1'b0; tmo = 1'b0; scyc = 0; a0 = '0; be0 = '0; wd0 = '0; wr0 = 1'b0;
    stable = 1'b1; ok = 1'b0; rv_after = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      t_req = 1'b0;
      if (o_read && o_write) stable = 1'b0;
      if (o_read || o_write) begin
        scyc++;
        if (scyc == 1) begin
          a0 = o_addr; be0 = o_be; wd0 = o_wd; wr0 = o_write;
        end else if (o_addr !== a0 || o_be !== be0 || o_wd !== wd0 || o_write !== wr0) begin
          stable = 1'b0;
        end
        t_wait = (scyc <= hold);
      end else begin
        t_wait = 1'b0;
      end
      if (o_rv) begin
        lat = c; rd = o_rdata; mis = o_mis; tmo = o_tmo; ok = 1'b1;
        break;
      end
    end
    t_wait = 1'b0;
    @(negedge clk);
    rv_after = o_rv | o_busy;
  endtask

  logic [31:0] rd, a0, wd0;
  logic [3:0]  be0;
  int          lat, scyc, rv_seen;
  bit          mis, tmo, wr0, stable, ok, rv_after;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_read", o_read, 0);
    check("rst_write", o_write, 0);
    check("rst_rv", o_rv, 0);
    check("rst_be", o_be, 0);
    check("rst_addr", o_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // LB signed at 0x1003
    t_rdata = 32'h80FF_1234;
    run_access(0, 2'd0, 1, 32'h1003, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LB  0x1003 rdata=%08h lat=%0d addr=%08h be=%b", rd, lat, a0, be0);
    check("lb_done", ok, 1);
    check("lb_addr", a0, 32'h1000);
    check("lb_be", be0, 4'b1000);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    check("lb_lat", lat, 2);
    check("lb_strobe", scyc, 1);
    check("lb_after", rv_after, 0);

    // LBU same access
    run_access(0, 2'd0, 0, 32'h1003, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LBU 0x1003 rdata=%08h lat=%0d", rd, lat);
    check("lbu_rdata", rd, 32'h0000_0080);

    // LB signed, positive byte at lane 1
    run_access(0, 2'd0, 1, 32'h1001, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LB  0x1001 rdata=%08h be=%b", rd, be0);
    check("lb1_rdata", rd, 32'h0000_0012);
    check("lb1_be", be0, 4'b0010);

    // SH at 0x2002
    run_access(1, 2'd1, 0, 32'h2002, 32'h0000_BEEF, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("SH  0x2002 wd=%08h be=%b write=%0d lat=%0d", wd0, be0, wr0, lat);
    check("sh_write", wr0, 1);
    check("sh_wd", wd0, 32'hBEEF_BEEF);
    check("sh_be", be0, 4'b1100);
    check("sh_addr", a0, 32'h2000);
    check("sh_lat", lat, 2);
    check("sh_mis", mis, 0);

    // SB at 0x11
    run_access(1, 2'd0, 0, 32'h11, 32'h1234_5678, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("SB  0x11 wd=%08h be=%b addr=%08h", wd0, be0, a0);
    check("sb_wd", wd0, 32'h7878_7878);
    check("sb_be", be0, 4'b0010);
    check("sb_addr", a0, 32'h10);

    // LH signed / unsigned
    t_rdata = 32'h9ABC_1234;
    run_access(0, 2'd1, 1, 32'h2002, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LH  0x2002 rdata=%08h", rd);
    check("lh_rdata", rd, 32'hFFFF_9ABC);
    run_access(0, 2'd1, 0, 32'h2000, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LHU 0x2000 rdata=%08h be=%b", rd, be0);
    check("lhu_rdata", rd, 32'h0000_1234);
    check("lhu_be", be0, 4'b0011);

    // Size 3 on a 32-bit bus behaves as word
    t_rdata = 32'h89AB_CDEF;
    run_access(0, 2'd3, 1, 32'h20, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LD3 0x20 rdata=%08h be=%b", rd, be0);
    check("sz3_rdata", rd, 32'h89AB_CDEF);
    check("sz3_be", be0, 4'b1111);

    // Misaligned word and half
    run_access(0, 2'd2, 0, 32'h1001, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LW  0x1001 mis=%0d lat=%0d strobes=%0d", mis, lat, scyc);
    check("lwmis_err", mis, 1);
    check("lwmis_lat", lat, 1);
    check("lwmis_strobe", scyc, 0);
    run_access(1, 2'd1, 0, 32'h2001, 32'h55, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("SH  0x2001 mis=%0d strobes=%0d", mis, scyc);
    check("shmis_err", mis, 1);
    check("shmis_strobe", scyc, 0);

    // waitrequest for 3 cycles
    t_rdata = 32'hCAFE_F00D;
    run_access(0, 2'd2, 0, 32'h3000, 0, 3, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LW  0x3000 wait3 rdata=%08h strobes=%0d stable=%0d lat=%0d", rd, scyc, stable, lat);
    check("wait_strobe", scyc, 4);
    check("wait_stable", stable, 1);
    check("wait_rdata", rd, 32'hCAFE_F00D);
    check("wait_lat", lat, 5);
    check("wait_tmo", tmo, 0);

    // waitrequest stuck high: timeout after 8 cycles
    run_access(0, 2'd2, 0, 32'h3004, 0, 1000, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("LW  0x3004 stuck tmo=%0d strobes=%0d rdata=%08h", tmo, scyc, rd);
    check("tmo_done", ok, 1);
    check("tmo_err", tmo, 1);
    check("tmo_strobe", scyc, 8);
    check("tmo_rdata", rd, 0);
    check("tmo_after", rv_after, 0);

    // Port B: reset while in the latency phase
    sel = 1'b1;
    t_rdata = 32'h1122_3344;
    @(negedge clk);
    t_req = 1'b1; t_write = 1'b0; t_size = 2'd2; t_signed = 1'b0; t_addr = 32'h40; t_wait = 1'b0;
    @(negedge clk);
    t_req = 1'b0;
    check("b_read", o_read, 1);
    @(negedge clk);
    check("b_lat_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    $display("RST in LAT busy=%0d addr=%08h be=%b", o_busy, o_addr, o_be);
    check("b_rst_busy", o_busy, 0);
    check("b_rst_addr", o_addr, 0);
    check("b_rst_be", o_be, 0);
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (o_rv) rv_seen++;
    end
    check("b_no_resp", rv_seen, 0);

    run_access(0, 2'd2, 0, 32'h44, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("B LW 0x44 rdata=%08h lat=%0d", rd, lat);
    check("b_rdata", rd, 32'h1122_3344);
    check("b_lat", lat, 5);
    t_rdata = 32'h8000_1234;
    run_access(0, 2'd1, 1, 32'h46, 0, 0, rd, lat, mis, tmo, scyc, a0, be0, wd0, wr0, stable, ok, rv_after);
    $display("B LH 0x46 rdata=%08h lat=%0d", rd, lat);
    check("b_lh_rdata", rd, 32'hFFFF_8000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
